wdc_seq: RTL and testbench

WDC_SEQ -- requirements
Module: wdc_seq

---
 rtl/crpa_wdc_pkg.sv | 19 +
 rtl/wdc_seq_cnt.sv | 27 ++
 rtl/wdc_seq.sv | 169 ++++++++++++++++
 tb/tb_wdc_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crpa_wdc_pkg.sv
// Shared definitions for the CRPA DC-wipe sequencer: state codes and parameter defaults.
package crpa_wdc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FREEZE = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    localparam int unsigned WDC_CLR_CYC_DEF   = 4;
    localparam int unsigned WDC_BLANK_MAX_DEF = 1024;

    // States in which a start pulse may (re)launch the acquisition sequence.
    function automatic logic is_startable(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_ERROR);
    endfunction

endpackage

// File: rtl/wdc_seq_cnt.sv
// Loadable saturating down-counter; o_zero flags the terminal count.
module wdc_seq_cnt #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wdc_seq.sv
// DC-wipe acquisition sequencer: clears, settles and supervises the per-antenna DC-removal filters.
module wdc_seq
    import crpa_wdc_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned CLR_CYC   = WDC_CLR_CYC_DEF,
    parameter int unsigned BLANK_MAX = WDC_BLANK_MAX_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             blank,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [CNT_W-1:0] settle_len,
    input  logic [N_CH-1:0]  wdc_valid,
    output logic [N_CH-1:0]  wdc_rstn,
    output logic [N_CH-1:0]  wdc_ena,
    output logic             ready,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state
);

    localparam int unsigned      CLR_W      = $clog2(CLR_CYC) + 1;
    localparam logic [CLR_W-1:0] CLR_LOAD   = CLR_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_MAX - 1);

    logic [2:0]       r_state;
    logic [N_CH-1:0]  r_mask;
    logic [CNT_W-1:0] r_len;
    logic             r_err;
    logic [CLR_W-1:0] r_clr_cnt;

    logic [2:0]       w_nxt;
    logic             w_accept;
    logic             w_fail;
    logic             w_all_valid;
    logic             w_set_ld;
    logic             w_set_dec;
    logic             w_set_zero;
    logic             w_blk_ld;
    logic             w_blk_dec;
    logic             w_blk_zero;
    logic [CNT_W-1:0] w_set_val;

    assign w_accept    = start && !stop && (ch_mask != '0) && is_startable(r_state);
    assign w_all_valid = ((wdc_valid & r_mask) == r_mask);
    // A zero settle length still spends one cycle in SETTLE.
    assign w_set_val   = (r_len == '0) ? '0 : (r_len - CNT_W'(1));

    always_comb begin
        w_nxt     = r_state;
        w_fail    = 1'b0;
        w_set_ld  = 1'b0;
        w_set_dec = 1'b0;
        w_blk_ld  = 1'b0;
        w_blk_dec = 1'b0;
        if (stop) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (w_accept) w_nxt = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        w_nxt    = ST_SETTLE;
                        w_set_ld = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_set_zero) begin
                        if (w_all_valid) begin
                            w_nxt = ST_RUN;
                        end else begin
                            w_nxt  = ST_ERROR;
                            w_fail = 1'b1;
                        end
                    end else begin
                        w_set_dec = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (blank) begin
                        w_nxt    = ST_FREEZE;
                        w_blk_ld = 1'b1;
                    end
                end
                // FREEZE may last at most BLANK_MAX blanked cycles before the estimate is stale.
                ST_FREEZE: begin
                    if (!blank) begin
                        w_nxt = ST_RUN;
                    end else if (w_blk_zero) begin
                        w_nxt = ST_CLEAR;
                    end else begin
                        w_blk_dec = 1'b1;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    wdc_seq_cnt #(.W(CNT_W)) u_settle_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_set_ld),
        .i_load_val (w_set_val),
        .i_dec      (w_set_dec),
        .o_zero     (w_set_zero)
    );

    wdc_seq_cnt #(.W(CNT_W)) u_blank_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_blk_ld),
        .i_load_val (BLANK_LOAD),
        .i_dec      (w_blk_dec),
        .o_zero     (w_blk_zero)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            if (stop) begin
                r_err <= 1'b0;
            end else if (w_accept) begin
                r_err  <= 1'b0;
                r_mask <= ch_mask;
                r_len  <= settle_len;
            end else if (w_fail) begin
                r_err <= 1'b1;
            end
            if ((w_nxt == ST_CLEAR) && (r_state != ST_CLEAR)) begin
                r_clr_cnt <= CLR_LOAD;
            end else if ((r_state == ST_CLEAR) && (r_clr_cnt != '0)) begin
                r_clr_cnt <= r_clr_cnt - CLR_W'(1);
            end
        end
    end

    // Outputs decode the registered state, so they trail a state change by one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wdc_rstn <= '1;
            wdc_ena  <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= r_state;
            wdc_rstn <= (r_state == ST_CLEAR) ? ~r_mask : '1;
            wdc_ena  <= ((r_state == ST_SETTLE) || (r_state == ST_RUN)) ? r_mask : '0;
            ready    <= (r_state == ST_RUN);
            busy     <= (r_state != ST_IDLE);
            err      <= r_err;
        end
    end

endmodule

// File: tb/tb_wdc_seq.sv
// Bench for wdc_seq: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_wdc_seq;

    localparam int NC   = 4;
    localparam int CW   = 20;
    localparam int CLR  = 4;
    localparam int BMAX = 1024;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_SETTLE = 2, S_RUN = 3, S_FREEZE = 4, S_ERROR = 5;

    logic          clk = 1'b0;
    logic          resetn, start, stop, blank;
    logic [NC-1:0] ch_mask, wdc_valid, wdc_rstn, wdc_ena;
    logic [CW-1:0] settle_len;
    logic          ready, busy, err;
    logic [2:0]    state;

    always #4 clk = ~clk;

    wdc_seq #(.N_CH(NC), .CNT_W(CW), .CLR_CYC(CLR), .BLANK_MAX(BMAX)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .blank      (blank),
        .ch_mask    (ch_mask),
        .settle_len (settle_len),
        .wdc_valid  (wdc_valid),
        .wdc_rstn   (wdc_rstn),
        .wdc_ena    (wdc_ena),
        .ready      (ready),
        .busy       (busy),
        .err        (err),
        .state      (state)
    );

    int checks = 0;
    int errors = 0;

    // Model: state, cycles spent in it so far, latched configuration and error flag.
    int            m_st, m_age, m_len;
    logic [NC-1:0] m_mask;
    logic          m_err;
    int            e_state, e_ready, e_busy, e_err;
    logic [NC-1:0] e_rstn, e_ena;

    int wcyc, fr, n_rstn_low, n_ena_off;
    int fs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int nxt;
        int tgt;
        if (!resetn) begin
            e_state = S_IDLE; e_rstn = '1; e_ena = '0; e_ready = 0; e_busy = 0; e_err = 0;
            m_st = S_IDLE; m_age = 1; m_mask = '0; m_len = 0; m_err = 1'b0;
            return;
        end
        e_state = m_st;
        e_rstn  = (m_st == S_CLEAR) ? ~m_mask : '1;
        e_ena   = (m_st == S_SETTLE || m_st == S_RUN) ? m_mask : '0;
        e_ready = (m_st == S_RUN) ? 1 : 0;
        e_busy  = (m_st != S_IDLE) ? 1 : 0;
        e_err   = int'(m_err);
        nxt = m_st;
        if (stop) begin
            nxt = S_IDLE;
            m_err = 1'b0;
        end else begin
            case (m_st)
                S_IDLE, S_ERROR:
                    if (start && ch_mask != '0) begin
                        nxt = S_CLEAR; m_mask = ch_mask; m_len = int'(settle_len); m_err = 1'b0;
                    end
                S_CLEAR: if (m_age >= CLR) nxt = S_SETTLE;
                S_SETTLE: begin
                    tgt = (m_len == 0) ? 1 : m_len;
                    if (m_age >= tgt) begin
                        if ((wdc_valid & m_mask) == m_mask) nxt = S_RUN;
                        else begin nxt = S_ERROR; m_err = 1'b1; end
                    end
                end
                S_RUN: if (blank) nxt = S_FREEZE;
                S_FREEZE: begin
                    if (!blank) nxt = S_RUN;
                    else if (m_age >= BMAX) nxt = S_CLEAR;
                end
                default: nxt = S_IDLE;
            endcase
        end
        m_age = (nxt != m_st) ? 1 : m_age + 1;
        m_st  = nxt;
    endtask

    task automatic clear_watch();
        wcyc = 0; fr = -1; n_rstn_low = 0; n_ena_off = 0;
        for (int s = 0; s < 8; s++) fs[s] = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        wcyc++;
        check("state", int'(state), e_state);
        check("wdc_rstn", int'(wdc_rstn), int'(e_rstn));
        check("wdc_ena", int'(wdc_ena), int'(e_ena));
        check("ready", int'(ready), e_ready);
        check("busy", int'(busy), e_busy);
        check("err", int'(err), e_err);
        for (int s = 0; s < 8; s++) if (fs[s] < 0 && int'(state) == s) fs[s] = wcyc;
        if (fr < 0 && ready) fr = wcyc;
        if (wdc_rstn != '1) n_rstn_low++;
        if (wdc_ena == '0) n_ena_off++;
    endtask

    task automatic watch(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int bh;
        bh = 0;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; blank = 1'b0;
        ch_mask = '0; settle_len = '0; wdc_valid = '0;
        clear_watch();
        watch(3);
        check("rst_state", int'(state), 0);
        check("rst_rstn", int'(wdc_rstn), 15);
        check("rst_busy", int'(busy), 0);
        resetn = 1'b1;
        watch(2);

        // Nominal acquisition, mask latched then input mask removed
        ch_mask = 4'hF; settle_len = 100; start = 1'b1;
        clear_watch();
        watch(1);
        start = 1'b0; ch_mask = '0;
        watch(49);
        wdc_valid = '1;
        watch(100);
        check("nom_clear_len", fs[S_SETTLE] - fs[S_CLEAR], 4);
        check("nom_settle_to_ready", fr - fs[S_SETTLE], 100);
        check("nom_run_ena", int'(wdc_ena), 15);
        check("nom_model_run", m_st, S_RUN);

        // Short blank
        clear_watch();
        blank = 1'b1;
        watch(200);
        blank = 1'b0;
        watch(10);
        check("sblank_ena_off", n_ena_off, 200);
        check("sblank_no_rst", n_rstn_low, 0);
        check("sblank_state", int'(state), S_RUN);

        // Long blank
        clear_watch();
        blank = 1'b1;
        watch(1100);
        blank = 1'b0;
        watch(150);
        check("lblank_freeze_len", fs[S_CLEAR] - fs[S_FREEZE], 1024);
        check("lblank_clear_len", fs[S_SETTLE] - fs[S_CLEAR], 4);
        check("lblank_rst_cycles", n_rstn_low, 4);
        check("lblank_state", int'(state), S_RUN);

        // Failed settle
        stop = 1'b1; watch(1); stop = 1'b0; watch(1);
        ch_mask = 4'b0101; settle_len = 30; wdc_valid = 4'b1011; start = 1'b1;
        clear_watch();
        watch(1);
        start = 1'b0;
        watch(45);
        check("fail_settle_len", fs[S_ERROR] - fs[S_SETTLE], 30);
        check("fail_err", int'(err), 1);
        check("fail_state", int'(state), S_ERROR);
        check("fail_model_err", int'(m_err), 1);
        ch_mask = 4'b0011; settle_len = 50; wdc_valid = '1; start = 1'b1;
        watch(1);
        start = 1'b0;
        watch(1);
        check("restart_state", int'(state), S_CLEAR);
        check("restart_err", int'(err), 0);
        check("restart_rstn", int'(wdc_rstn), 12);

        // Start and stop together in SETTLE; zero-mask start ignored
        watch(8);
        check("ss_in_settle", int'(state), S_SETTLE);
        start = 1'b1; stop = 1'b1; ch_mask = 4'hF;
        watch(1);
        start = 1'b0; stop = 1'b0;
        watch(1);
        check("ss_state", int'(state), S_IDLE);
        check("ss_busy", int'(busy), 0);
        ch_mask = '0; start = 1'b1;
        watch(1);
        start = 1'b0;
        watch(3);
        check("zmask_state", int'(state), S_IDLE);
        check("zmask_busy", int'(busy), 0);

        // Zero settle length, then reset in FREEZE
        ch_mask = 4'hF; settle_len = 0; wdc_valid = '1; start = 1'b1;
        clear_watch();
        watch(1);
        start = 1'b0;
        watch(10);
        check("zlen_settle_len", fs[S_RUN] - fs[S_SETTLE], 1);
        blank = 1'b1;
        watch(5);
        check("frz_state", int'(state), S_FREEZE);
        resetn = 1'b0;
        watch(1);
        check("rstfrz_state", int'(state), 0);
        check("rstfrz_rstn", int'(wdc_rstn), 15);
        check("rstfrz_ena", int'(wdc_ena), 0);
        check("rstfrz_ready", int'(ready), 0);
        check("rstfrz_busy", int'(busy), 0);
        check("rstfrz_err", int'(err), 0);
        resetn = 1'b1; blank = 1'b0;
        clear_watch();
        watch(5);
        check("rstfrz_no_pulse", n_rstn_low, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            resetn     = ($urandom_range(0, 599) != 0);
            stop       = ($urandom_range(0, 149) == 0);
            start      = ($urandom_range(0, 14) == 0);
            ch_mask    = ($urandom_range(0, 7) == 0) ? '0 : 4'($urandom);
            settle_len = 20'($urandom_range(0, 40));
            wdc_valid  = ($urandom_range(0, 5) != 0) ? '1 : 4'($urandom);
            if (bh > 0) begin
                blank = 1'b1;
                bh--;
            end else if (blank) begin
                blank = ($urandom_range(0, 39) != 0);
            end else begin
                blank = ($urandom_range(0, 59) == 0);
                if (blank && $urandom_range(0, 7) == 0) bh = 1030;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
